mmio_fifo_ctrl: RTL and testbench
=================================

# mmio_fifo_ctrl

Controller that sequences a fixed-depth, 1-cycle-read-latency FIFO behind the AFU's CCI-P MMIO decode. It turns MMIO writes to the DATA register into FIFO pushes and MMIO reads of DATA into FIFO pops. It tracks occupancy and sticky error flags, exposes STATUS/CTRL registers, and returns every MMIO read response, with its TID, at a uniform fixed latency. It sits between the registered Rx c0 MMIO fields and the Tx c2 response registers.

## Interface
- DEPTH, 8, FIFO entries; legal range 2..255
- ADDR_DATA, 16'h0020, DATA register (push on write, pop on read)
- ADDR_STATUS, 16'h0022, STATUS register (read-only)
- ADDR_CTRL, 16'h0024, CTRL register (write-only, reads return 0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  MMIO write strobe (already registered)
- wr_addr  in  16  MMIO write address
- wr_data  in  64  MMIO write data
- rd_valid  in  1  MMIO read strobe (already registered)
- rd_addr  in  16  MMIO read address
- rd_tid  in  9  MMIO read transaction ID
- fifo_wr_en  out  1  push strobe, combinational from inputs
- fifo_wr_data  out  64  push data (= wr_data)
- fifo_rd_en  out  1  pop strobe, combinational from inputs
- fifo_rd_data  in  64  head data, valid the cycle after fifo_rd_en
- fifo_flush  out  1  registered one-cycle flush pulse
- rsp_valid  out  1  read response valid, registered
- rsp_tid  out  9  response TID
- rsp_data  out  64  response data
- count  out  8  occupancy
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Push: wr_valid && wr_addr==ADDR_DATA. If !full, fifo_wr_en=1. If full, no push; set overflow. A concurrent pop does not make room.
- Pop: rd_valid && rd_addr==ADDR_DATA. If !empty, fifo_rd_en=1. If empty, no pop; set underflow; response data 0. A concurrent push does not satisfy the pop.
- Push and pop accepted in the same cycle: count unchanged.
- count: +1 per accepted push, -1 per accepted pop. Never exceeds DEPTH; never wraps below 0.
- CTRL write, bit0: clear overflow/underflow. A new error event in the same cycle wins (flag stays set).
- CTRL write, bit1: flush. count becomes 0 next cycle; fifo_flush pulses next cycle.
- Flush has priority over a same-cycle push or pop. Both are suppressed with no flags set. A suppressed pop responds with data 0.
- STATUS read returns a snapshot of pre-cycle state:
  - [7:0] count
  - [8] empty
  - [9] full
  - [10] overflow
  - [11] underflow
  - [39:32] DEPTH
  - other bits 0
- Unmapped reads return 0. Writes to unmapped addresses or STATUS are ignored.
- Read pipeline has two stages, each carrying {valid, tid, sel, snapshot}. Stage 2 muxes fifo_rd_data for a successful DATA pop, otherwise the snapshot or 0.
- Back-to-back reads every cycle are supported; no stall or backpressure exists.

## Timing
- A read sampled in cycle N produces rsp_valid=1 in cycle N+2 for exactly one cycle, with rsp_tid=rd_tid(N). This holds for every address.
- fifo_rd_en is asserted in cycle N; fifo_rd_data is captured at the end of N+1.
- Push/pop effects on count, full, empty are visible in N+1.
- Reset (async assert) clears:
  - count=0, empty=1, full=0
  - overflow=underflow=0
  - fifo_flush=0
  - rsp_valid=0, rsp_tid=0, rsp_data=0
  - both pipeline stages
- fifo_wr_en and fifo_rd_en are 0 while rst=1.
- In-flight reads are discarded at reset; no response is issued for them.

## Test plan
- Reset, then read STATUS → response at +2 cycles: data 64'h0000_0008_0000_0100, tid echoed.
- Push 3 values (0xA, 0xB, 0xC), then pop 3 back-to-back with tids 1,2,3 → rsp_valid on 3 consecutive cycles, data A,B,C, tids 1,2,3; count returns to 0.
- Push 9 times at DEPTH=8 → 8 fifo_wr_en pulses, full=1, STATUS bit10=1. Then write CTRL=1 → bit10 clears.
- Pop when empty → response data 0, underflow=1, no fifo_rd_en. A same-cycle push is still accepted, count=1.
- Push 5, then CTRL=2 in the same cycle as a pop → fifo_flush pulse, count=0, pop response 0, no flags set.
- Assert rst between a DATA read request and its response → no rsp_valid after reset; all outputs at reset values.

Source files
------------

// File: rtl/mmio_fifo_ctrl_if.sv
// MMIO request/response bundle between the registered CCI-P Rx c0 decode
// and the Tx c2 response registers, as seen by the FIFO controller.
interface mmio_fifo_ctrl_if;
    // Write request (already registered upstream)
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    // Read request (already registered upstream)
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic [8:0]  rd_tid;
    // Read response, fixed latency
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    // MMIO decode side: issues requests, receives responses
    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr, rd_tid,
        input  rsp_valid, rsp_tid, rsp_data
    );

    // Controller side
    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr, rd_tid,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-to-FIFO controller: DATA writes push, DATA reads pop, STATUS/CTRL
// registers, sticky overflow/underflow flags, and a two-stage read pipeline
// that answers every MMIO read exactly two cycles after it is sampled.
// DEPTH must lie in 2..255 so that occupancy fits the 8-bit count.
module mmio_fifo_ctrl #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] ADDR_DATA   = 16'h0020,
    parameter logic [15:0] ADDR_STATUS = 16'h0022,
    parameter logic [15:0] ADDR_CTRL   = 16'h0024
) (
    input  logic                clk,
    input  logic                rst,
    mmio_fifo_ctrl_if.slave     bus,
    output logic                fifo_wr_en,
    output logic [63:0]         fifo_wr_data,
    output logic                fifo_rd_en,
    input  logic [63:0]         fifo_rd_data,
    output logic                fifo_flush,
    output logic [7:0]          count,
    output logic                full,
    output logic                empty
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    // What stage 2 drives onto rsp_data for a given read
    typedef enum logic [1:0] {
        SEL_ZERO,   // unmapped, CTRL, failed or suppressed pop
        SEL_SNAP,   // STATUS snapshot taken when the read was sampled
        SEL_FIFO    // head data returned by the FIFO one cycle after the pop
    } rsp_sel_e;

    // Decode and accept/reject decisions
    logic       wr_hit_data;
    logic       wr_hit_ctrl;
    logic       rd_hit_data;
    logic       rd_hit_status;
    logic       flush_req;
    logic       clear_req;
    logic       push_ok;
    logic       pop_ok;
    logic       overflow_evt;
    logic       underflow_evt;

    // Controller state and next-state
    logic       overflow;
    logic       underflow;
    logic [7:0] count_next;
    logic       overflow_next;
    logic       underflow_next;
    logic [63:0] status_word;
    rsp_sel_e   s1_sel_next;

    // Read pipeline stage 1
    logic       s1_valid;
    logic [8:0] s1_tid;
    rsp_sel_e   s1_sel;
    logic [63:0] s1_snap;

    // Read pipeline stage 2 (response registers)
    logic       rsp_valid_q;
    logic [8:0] rsp_tid_q;
    logic [63:0] rsp_data_q;

    assign full  = (count == DEPTH_B);
    assign empty = (count == 8'd0);

    // Decode the MMIO strobes, decide push/pop acceptance and compute next state
    always_comb begin
        // NOTE: every signal this block writes gets a default first, so no
        // path through the logic leaves one unassigned and infers a latch.
        wr_hit_data    = 1'b0;
        wr_hit_ctrl    = 1'b0;
        rd_hit_data    = 1'b0;
        rd_hit_status  = 1'b0;
        flush_req      = 1'b0;
        clear_req      = 1'b0;
        push_ok        = 1'b0;
        pop_ok         = 1'b0;
        overflow_evt   = 1'b0;
        underflow_evt  = 1'b0;
        count_next     = count;
        overflow_next  = overflow;
        underflow_next = underflow;
        status_word    = '0;
        s1_sel_next    = SEL_ZERO;

        wr_hit_data   = bus.wr_valid && (bus.wr_addr == ADDR_DATA);
        wr_hit_ctrl   = bus.wr_valid && (bus.wr_addr == ADDR_CTRL);
        rd_hit_data   = bus.rd_valid && (bus.rd_addr == ADDR_DATA);
        rd_hit_status = bus.rd_valid && (bus.rd_addr == ADDR_STATUS);

        flush_req = wr_hit_ctrl && bus.wr_data[1];
        clear_req = wr_hit_ctrl && bus.wr_data[0];

        // Acceptance uses pre-cycle full/empty: a same-cycle pop never makes
        // room for a push and a same-cycle push never feeds a pop. Flush wins
        // over both and suppresses their error events too.
        push_ok       = !rst && wr_hit_data && !full  && !flush_req;
        pop_ok        = !rst && rd_hit_data && !empty && !flush_req;
        overflow_evt  = wr_hit_data && full  && !flush_req;
        underflow_evt = rd_hit_data && empty && !flush_req;

        if (flush_req) begin
            count_next = 8'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_next = count + 8'd1;
                2'b01:   count_next = count - 8'd1;
                default: count_next = count;
            endcase
        end

        // A fresh error event beats a same-cycle clear
        overflow_next  = overflow_evt  || (overflow  && !clear_req);
        underflow_next = underflow_evt || (underflow && !clear_req);

        status_word[7:0]   = count;
        status_word[8]     = empty;
        status_word[9]     = full;
        status_word[10]    = overflow;
        status_word[11]    = underflow;
        status_word[39:32] = DEPTH_B;

        if (pop_ok) begin
            s1_sel_next = SEL_FIFO;
        end else if (rd_hit_status) begin
            s1_sel_next = SEL_SNAP;
        end
    end

    assign fifo_wr_en   = push_ok;
    assign fifo_wr_data = bus.wr_data;
    assign fifo_rd_en   = pop_ok;

    // Occupancy, sticky error flags and the one-cycle flush pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 8'd0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            fifo_flush <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from the same pre-edge values, independent of statement order.
            count      <= count_next;
            overflow   <= overflow_next;
            underflow  <= underflow_next;
            fifo_flush <= flush_req;
        end
    end

    // Stage 1: capture the read request, its response source and the STATUS snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tid   <= '0;
            s1_sel   <= SEL_ZERO;
            s1_snap  <= '0;
        end else begin
            s1_valid <= bus.rd_valid;
            s1_tid   <= bus.rd_tid;
            s1_sel   <= s1_sel_next;
            s1_snap  <= status_word;
        end
    end

    // Stage 2: pick the response data, picking up FIFO head data one cycle after the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= s1_valid;
            rsp_tid_q   <= s1_tid;
            case (s1_sel)
                SEL_FIFO: rsp_data_q <= fifo_rd_data;
                SEL_SNAP: rsp_data_q <= s1_snap;
                default:  rsp_data_q <= '0;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tid   = rsp_tid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Self-checking bench for mmio_fifo_ctrl: directed scenarios followed by
// random MMIO traffic, all compared against a queue-based reference model.
// The bench also provides the 1-cycle-latency FIFO storage behind the DUT.
module tb_mmio_fifo_ctrl;

    localparam int          DEPTH       = 8;
    localparam logic [15:0] ADDR_DATA   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0022;
    localparam logic [15:0] ADDR_CTRL   = 16'h0024;

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        fifo_wr_en;
    logic [63:0] fifo_wr_data;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic        fifo_flush;
    logic [7:0]  count;
    logic        full;
    logic        empty;

    mmio_fifo_ctrl_if bus ();

    mmio_fifo_ctrl #(
        .DEPTH       (DEPTH),
        .ADDR_DATA   (ADDR_DATA),
        .ADDR_STATUS (ADDR_STATUS),
        .ADDR_CTRL   (ADDR_CTRL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_flush   (fifo_flush),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO storage behind the controller: flush first, then pop, then push
    logic [63:0] mem_q[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q.delete();
            fifo_rd_data <= '0;
        end else begin
            if (fifo_flush) mem_q.delete();
            if (fifo_rd_en) begin
                if (mem_q.size() > 0) fifo_rd_data <= mem_q.pop_front();
                else                  fifo_rd_data <= '1;
            end
            if (fifo_wr_en) mem_q.push_back(fifo_wr_data);
        end
    end

    // Reference model state
    logic [63:0] mq[$];
    rsp_t        exp_rsp[$];
    logic        m_ovf;
    logic        m_ufl;
    logic        m_flush_prev;
    int          cyc;
    int          wr_pulses;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_rsp.delete();
        m_ovf        = 1'b0;
        m_ufl        = 1'b0;
        m_flush_prev = 1'b0;
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model
    task automatic cycle(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                         input logic rv, input logic [15:0] ra, input logic [8:0] tid);
        logic        w_data, w_ctrl, fl, clr, r_data, e_push, e_pop;
        int          size;
        logic [63:0] st;
        rsp_t        r;
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        bus.rd_tid   = tid;
        @(negedge clk);
        w_data = wv && (wa == ADDR_DATA);
        w_ctrl = wv && (wa == ADDR_CTRL);
        fl     = w_ctrl && wd[1];
        clr    = w_ctrl && wd[0];
        r_data = rv && (ra == ADDR_DATA);
        size   = mq.size();
        e_push = w_data && !fl && (size < DEPTH);
        e_pop  = r_data && !fl && (size > 0);

        check("fifo_wr_en", 64'(fifo_wr_en), 64'(e_push));
        if (e_push) check("fifo_wr_data", fifo_wr_data, wd);
        check("fifo_rd_en", 64'(fifo_rd_en), 64'(e_pop));
        check("count", 64'(count), 64'(size));
        check("full", 64'(full), 64'(size == DEPTH));
        check("empty", 64'(empty), 64'(size == 0));
        check("fifo_flush", 64'(fifo_flush), 64'(m_flush_prev));
        if (fifo_wr_en) wr_pulses++;

        if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
            r = exp_rsp.pop_front();
            check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("rsp_tid", 64'(bus.rsp_tid), 64'(r.tid));
            check("rsp_data", bus.rsp_data, r.data);
        end else begin
            check("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
        end

        if (rv) begin
            st        = '0;
            st[7:0]   = 8'(size);
            st[8]     = (size == 0);
            st[9]     = (size == DEPTH);
            st[10]    = m_ovf;
            st[11]    = m_ufl;
            st[39:32] = 8'(DEPTH);
            r.due = cyc + 2;
            r.tid = tid;
            if (r_data)                  r.data = e_pop ? mq[0] : 64'd0;
            else if (ra == ADDR_STATUS)  r.data = st;
            else                         r.data = 64'd0;
            exp_rsp.push_back(r);
        end

        if (fl) begin
            mq.delete();
        end else begin
            if (e_pop)  void'(mq.pop_front());
            if (e_push) mq.push_back(wd);
        end
        m_ovf        = (w_data && !fl && size == DEPTH) || (m_ovf && !clr);
        m_ufl        = (r_data && !fl && size == 0)     || (m_ufl && !clr);
        m_flush_prev = fl;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 9'h0);
    endtask

    task automatic push(input logic [63:0] d);
        cycle(1'b1, ADDR_DATA, d, 1'b0, 16'h0, 9'h0);
    endtask

    task automatic pop(input logic [8:0] tid);
        cycle(1'b0, 16'h0, 64'h0, 1'b1, ADDR_DATA, tid);
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] tid);
        cycle(1'b0, 16'h0, 64'h0, 1'b1, a, tid);
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        cycle(1'b1, a, d, 1'b0, 16'h0, 9'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_flush"}, 64'(fifo_flush), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_tid"}, 64'(bus.rsp_tid), 64'd0);
        check({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        wv, rv;
        logic [15:0] wa, ra;
        logic [63:0] wd;
        logic [8:0]  tid;
        int          r;

        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        wr_pulses = 0;
        model_reset();

        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_tid   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // STATUS right after reset
        rd(ADDR_STATUS, 9'h1A5);
        repeat (3) idle();

        // Push A, B, C then pop them back-to-back
        push(64'hA);
        push(64'hB);
        push(64'hC);
        pop(9'd1);
        pop(9'd2);
        pop(9'd3);
        repeat (3) idle();

        // Overfill, inspect STATUS, clear the flag, drain
        wr_pulses = 0;
        for (int i = 0; i < 9; i++) push(64'h100 + 64'(i));
        check("push9_pulses", 64'(wr_pulses), 64'd8);
        rd(ADDR_STATUS, 9'h010);
        repeat (2) idle();
        wr(ADDR_CTRL, 64'h1);
        rd(ADDR_STATUS, 9'h011);
        for (int i = 0; i < 8; i++) pop(9'(32 + i));
        repeat (2) idle();

        // Pop on empty with a same-cycle push
        cycle(1'b1, ADDR_DATA, 64'h77, 1'b1, ADDR_DATA, 9'h044);
        rd(ADDR_STATUS, 9'h045);
        rd(ADDR_CTRL, 9'h046);
        rd(16'h0100, 9'h047);
        wr(ADDR_STATUS, 64'hFFFF);
        wr(ADDR_CTRL, 64'h1);
        repeat (2) idle();

        // Flush concurrent with a pop
        for (int i = 0; i < 5; i++) push(64'hF00 + 64'(i));
        cycle(1'b1, ADDR_CTRL, 64'h2, 1'b1, ADDR_DATA, 9'h0F0);
        rd(ADDR_STATUS, 9'h0F1);
        repeat (3) idle();

        // Reset between a DATA read and its response
        push(64'hDEAD);
        push(64'hBEEF);
        pop(9'h0AB);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_DATA;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = ADDR_DATA;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("inrst");
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) idle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            wv = ($urandom_range(0, 99) < 55);
            r  = $urandom_range(0, 99);
            wa = (r < 70) ? ADDR_DATA : (r < 80) ? ADDR_CTRL : (r < 90) ? ADDR_STATUS : 16'($urandom);
            wd = {32'($urandom), 32'($urandom)};
            if (wa == ADDR_CTRL && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
            rv = ($urandom_range(0, 99) < 50);
            r  = $urandom_range(0, 99);
            ra = (r < 60) ? ADDR_DATA : (r < 75) ? ADDR_STATUS : (r < 85) ? ADDR_CTRL : 16'($urandom);
            tid = 9'($urandom);
            cycle(wv, wa, wd, rv, ra, tid);
        end
        repeat (3) idle();
        check("rsp_drain", 64'(exp_rsp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
